// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle RV32I sequencer: owns the PC, fetches over imem, and strobes the datapath
// through EXEC/MEM/WB. Define PERF_CNT_EN to enable cycle_count/instret_count (tied to 0 otherwise).
module rv32i_seq_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] instr_q,
   output logic        alu_en,
   output logic        rf_we,
   output logic [31:0] pc,
   output logic [2:0]  state,
   output logic        retired,
   output logic        illegal,
   output logic        timeout,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Count value seen on the last permitted wait cycle; no ack there means trap.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  wait_cnt;
   logic [6:0]  opc;
   logic        is_load, is_store, is_branch, is_jal, is_jalr, is_legal;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        retire_now;

   assign state     = state_q;
   assign imem_addr = pc;
   assign opc       = instr_q[6:0];
   assign pc_plus4  = pc + 32'd4;

   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign is_branch = (opc == OPC_BRANCH);
   assign is_jal    = (opc == OPC_JAL);
   assign is_jalr   = (opc == OPC_JALR);
   assign is_legal  = is_load | is_store | is_branch | is_jal | is_jalr |
                      (opc == OPC_OPIMM) | (opc == OPC_OP) |
                      (opc == OPC_LUI)   | (opc == OPC_AUIPC);

   // Retire points: branch in EXEC, acked store in MEM, every WB.
   always_comb begin
      retire_now = 1'b0;
      next_pc    = pc_plus4;
      case (state_q)
         S_EXEC: begin
            if (is_branch) begin
               retire_now = 1'b1;
               next_pc    = branch_taken ? branch_target : pc_plus4;
            end
         end
         S_MEM: begin
            if (dmem_ack && is_store) retire_now = 1'b1;
         end
         S_WB: begin
            retire_now = 1'b1;
            if (is_jal)       next_pc = jump_target;
            else if (is_jalr) next_pc = {jump_target[31:1], 1'b0};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc       <= RESET_PC;
         instr_q  <= '0;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         alu_en   <= 1'b0;
         rf_we    <= 1'b0;
         retired  <= 1'b0;
         illegal  <= 1'b0;
         timeout  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         alu_en  <= 1'b0;
         rf_we   <= 1'b0;
         retired <= 1'b0;
         if (retire_now) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (next_pc[1:0] != 2'b00) begin
               state_q <= S_TRAP;
               illegal <= 1'b1;
            end else begin
               pc      <= next_pc;
               retired <= 1'b1;
               if (run) begin
                  state_q  <= S_FETCH;
                  imem_req <= 1'b1;
                  wait_cnt <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (run) begin
                     state_q  <= S_FETCH;
                     imem_req <= 1'b1;
                     wait_cnt <= '0;
                  end
               end
               S_FETCH: begin
                  if (imem_ack) begin
                     instr_q  <= imem_rdata;
                     imem_req <= 1'b0;
                     state_q  <= S_DECODE;
                  end else if (wait_cnt == WAIT_LAST) begin
                     imem_req <= 1'b0;
                     timeout  <= 1'b1;
                     state_q  <= S_TRAP;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
               S_DECODE: begin
                  if (is_legal) begin
                     state_q <= S_EXEC;
                     alu_en  <= 1'b1;
                  end else begin
                     state_q <= S_TRAP;
                     illegal <= 1'b1;
                  end
               end
               S_EXEC: begin
                  if (is_load || is_store) begin
                     state_q  <= S_MEM;
                     dmem_req <= 1'b1;
                     dmem_we  <= is_store;
                     wait_cnt <= '0;
                  end else begin
                     state_q <= S_WB;
                     rf_we   <= 1'b1;
                  end
               end
               S_MEM: begin
                  // Only loads get here on ack; acked stores retire above.
                  if (dmem_ack) begin
                     dmem_req <= 1'b0;
                     dmem_we  <= 1'b0;
                     state_q  <= S_WB;
                     rf_we    <= 1'b1;
                  end else if (wait_cnt == WAIT_LAST) begin
                     dmem_req <= 1'b0;
                     dmem_we  <= 1'b0;
                     timeout  <= 1'b1;
                     state_q  <= S_TRAP;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end
               S_WB:   ;
               S_TRAP: ;
               default: begin
                  state_q  <= S_IDLE;
                  imem_req <= 1'b0;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_TRAP) cycle_count <= cycle_count + 32'd1;
         if (retired) instret_count <= instret_count + 32'd1;
      end
   end
`else
   assign cycle_count   = '0;
   assign instret_count = '0;
`endif

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Bench for rv32i_seq_ctrl: an instruction-level model expands each instruction into an
// expected per-cycle trace (plus the stimulus for that cycle) which is replayed and compared.
module tb_rv32i_seq_ctrl;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TMO    = 16;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
   logic [31:0] imem_rdata = '0, branch_target = '0, jump_target = '0;
   logic        imem_req, dmem_req, dmem_we, alu_en, rf_we, retired, illegal, timeout;
   logic [31:0] imem_addr, instr_q, pc, cycle_count, instret_count;
   logic [2:0]  state;

   always #5 clk = ~clk;

   rv32i_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .branch_taken(branch_taken), .branch_target(branch_target), .jump_target(jump_target),
      .instr_q(instr_q), .alu_en(alu_en), .rf_we(rf_we), .pc(pc), .state(state),
      .retired(retired), .illegal(illegal), .timeout(timeout),
      .cycle_count(cycle_count), .instret_count(instret_count)
   );

   typedef struct {
      logic [2:0]  st;
      logic        ireq, dreq, dwe, alu, rfw, ret, ill, tmo;
      logic [31:0] pcv, iq;
      logic        run_i, iack, dack, btk;
      logic [31:0] rdata, btgt, jtgt;
   } cyc_t;

   typedef enum {K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_ALU, K_BAD} kind_t;

   cyc_t        q[$];
   int          checks = 0, failures = 0, cyc = 0;
   logic [31:0] m_pc, m_instr, exp_cyc, exp_ins;
   logic        m_ret, m_idle, m_trap, m_ill, m_tmo;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
      end
   endtask

   function automatic kind_t kind_of(input logic [31:0] ins);
      case (ins[6:0])
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b1100011: return K_BR;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: return K_ALU;
         default: return K_BAD;
      endcase
   endfunction

   // One expected cycle: outputs follow the model, inputs are noise unless overridden.
   task automatic mk(input logic [2:0] st, output cyc_t r);
      r.st = st; r.ireq = 0; r.dreq = 0; r.dwe = 0; r.alu = 0; r.rfw = 0;
      r.ret = m_ret; m_ret = 0;
      r.ill = m_ill; r.tmo = m_tmo; r.pcv = m_pc; r.iq = m_instr;
      r.run_i = 1'($urandom_range(0, 1)); r.iack = 1'($urandom_range(0, 1));
      r.dack = 1'($urandom_range(0, 1)); r.btk = 1'($urandom_range(0, 1));
      r.rdata = $urandom; r.btgt = $urandom; r.jtgt = $urandom;
   endtask

   task automatic enter_trap(input bit is_tmo);
      cyc_t r;
      if (is_tmo) m_tmo = 1; else m_ill = 1;
      m_trap = 1;
      for (int i = 0; i < 4; i++) begin mk(3'd6, r); q.push_back(r); end
   endtask

   task automatic retire(input cyc_t r, input logic [31:0] npc, input logic run_after);
      r.run_i = run_after;
      q.push_back(r);
      if (npc[1:0] != 2'b00) enter_trap(0);
      else begin m_pc = npc; m_ret = 1; m_idle = !run_after; end
   endtask

   task automatic gen_instr(input logic [31:0] ins, input int df, input int dm,
                            input logic btk, input logic [31:0] tgt, input logic run_after);
      cyc_t r; kind_t k; int n;
      if (m_trap) return;
      k = kind_of(ins);
      if (m_idle) begin
         n = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) begin mk(3'd0, r); r.run_i = 0; q.push_back(r); end
         mk(3'd0, r); r.run_i = 1; q.push_back(r);
         m_idle = 0;
      end
      n = (df >= TMO) ? TMO : df + 1;
      for (int i = 0; i < n; i++) begin
         mk(3'd1, r); r.ireq = 1; r.iack = (df < TMO && i == df); r.rdata = ins; q.push_back(r);
      end
      if (df >= TMO) begin enter_trap(1); return; end
      m_instr = ins;
      mk(3'd2, r); q.push_back(r);
      if (k == K_BAD) begin enter_trap(0); return; end
      mk(3'd3, r); r.alu = 1;
      if (k == K_BR) begin
         r.btk = btk; r.btgt = tgt;
         retire(r, btk ? tgt : m_pc + 32'd4, run_after);
         return;
      end
      q.push_back(r);
      if (k == K_LOAD || k == K_STORE) begin
         n = (dm >= TMO) ? TMO : dm + 1;
         for (int i = 0; i < n; i++) begin
            mk(3'd4, r); r.dreq = 1; r.dwe = (k == K_STORE); r.dack = (dm < TMO && i == dm);
            if (k == K_STORE && r.dack) begin retire(r, m_pc + 32'd4, run_after); return; end
            q.push_back(r);
         end
         if (dm >= TMO) begin enter_trap(1); return; end
      end
      mk(3'd5, r); r.rfw = 1; r.jtgt = tgt;
      retire(r, (k == K_JAL) ? tgt : (k == K_JALR) ? (tgt & ~32'h1) : m_pc + 32'd4, run_after);
   endtask

   task automatic play(input int n);
      cyc_t r; int cnt = 0;
      while (q.size() > 0 && (n < 0 || cnt < n)) begin
         r = q.pop_front();
         chk("state", 32'(state), 32'(r.st));
         chk("imem_req", 32'(imem_req), 32'(r.ireq));
         chk("imem_addr", imem_addr, r.pcv);
         chk("dmem_req", 32'(dmem_req), 32'(r.dreq));
         chk("dmem_we", 32'(dmem_we), 32'(r.dwe));
         chk("alu_en", 32'(alu_en), 32'(r.alu));
         chk("rf_we", 32'(rf_we), 32'(r.rfw));
         chk("retired", 32'(retired), 32'(r.ret));
         chk("pc", pc, r.pcv);
         chk("illegal", 32'(illegal), 32'(r.ill));
         chk("timeout", 32'(timeout), 32'(r.tmo));
         chk("instr_q", instr_q, r.iq);
         chk("cycle_count", cycle_count, PERF ? exp_cyc : 32'h0);
         chk("instret_count", instret_count, PERF ? exp_ins : 32'h0);
         if (r.st != 3'd0 && r.st != 3'd6) exp_cyc = exp_cyc + 32'd1;
         if (r.ret) exp_ins = exp_ins + 32'd1;
         run = r.run_i; imem_ack = r.iack; imem_rdata = r.rdata; dmem_ack = r.dack;
         branch_taken = r.btk; branch_target = r.btgt; jump_target = r.jtgt;
         @(negedge clk);
         cyc++; cnt++;
      end
   endtask

   // Acks are held high through reset; they must not leak into the first IDLE cycle.
   task automatic do_reset();
      reset = 1; imem_ack = 1; dmem_ack = 1; run = 1;
      @(negedge clk); @(negedge clk);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr_q", instr_q, 32'h0);
      chk("rst_imem_req", 32'(imem_req), 32'h0);
      chk("rst_dmem_req", 32'(dmem_req), 32'h0);
      chk("rst_strobes", 32'({alu_en, rf_we, retired, dmem_we}), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      chk("rst_counts", cycle_count | instret_count, 32'h0);
      reset = 0;
      q.delete();
      m_pc = RST_PC; m_instr = '0; m_ret = 0; m_idle = 1; m_trap = 0; m_ill = 0; m_tmo = 0;
      exp_cyc = '0; exp_ins = '0;
   endtask

   task automatic gen_random();
      logic [31:0] ins, tgt; int sel, df, dm;
      ins = $urandom;
      sel = $urandom_range(0, 39);
      if (sel < 4)       ins[6:0] = 7'b0000011;
      else if (sel < 8)  ins[6:0] = 7'b0100011;
      else if (sel < 14) ins[6:0] = 7'b1100011;
      else if (sel < 17) ins[6:0] = 7'b1101111;
      else if (sel < 20) ins[6:0] = 7'b1100111;
      else if (sel < 26) ins[6:0] = 7'b0010011;
      else if (sel < 30) ins[6:0] = 7'b0110011;
      else if (sel < 34) ins[6:0] = 7'b0110111;
      else if (sel < 39) ins[6:0] = 7'b0010111;
      else begin
         do ins[6:0] = 7'($urandom); while (kind_of(ins) != K_BAD);
      end
      tgt = $urandom;
      if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
      df = $urandom_range(0, 3);
      sel = $urandom_range(0, 39);
      if (sel == 0) df = TMO; else if (sel < 3) df = TMO - 1;
      dm = $urandom_range(0, 3);
      sel = $urandom_range(0, 39);
      if (sel == 0) dm = TMO; else if (sel < 3) dm = TMO - 1;
      gen_instr(ins, df, dm, 1'($urandom_range(0, 1)), tgt, ($urandom_range(0, 3) != 0));
   endtask

   initial begin
      do_reset();
      // ADDI x1,x0,5 acked on the first fetch cycle
      gen_instr(32'h00500093, 0, 0, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_addi_pc", pc, 32'h4);
      chk("lit_addi_ret", 32'(retired), 32'h1);
      // LW with ack on the third MEM cycle
      gen_instr(32'h0000A103, 0, 2, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_lw_pc", pc, 32'h8);
      gen_instr(32'h00500093, 1, 0, 1'b0, 32'h0, 1'b1);
      gen_instr(32'h00500093, 0, 0, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_pre_beq_pc", pc, 32'h10);
      gen_instr(32'h00208063, 0, 0, 1'b1, 32'h40, 1'b1); play(-1);
      chk("lit_beq_taken", pc, 32'h40);
      gen_instr(32'h00208063, 2, 0, 1'b0, 32'h80, 1'b1); play(-1);
      chk("lit_beq_not_taken", pc, 32'h44);
      // JAL to the top word, then wrap to 0 and stop in IDLE
      gen_instr(32'h0000006F, 0, 0, 1'b0, 32'hFFFF_FFFC, 1'b1); play(-1);
      chk("lit_jal_pc", pc, 32'hFFFF_FFFC);
      gen_instr(32'h00500093, 0, 0, 1'b0, 32'h0, 1'b0); play(-1);
      chk("lit_wrap_pc", pc, 32'h0);
      chk("lit_wrap_idle", 32'(state), 32'h0);

      do_reset();
      gen_instr(32'h0000007F, 0, 0, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_bad_state", 32'(state), 32'h6);
      chk("lit_bad_illegal", 32'(illegal), 32'h1);
      chk("lit_bad_imem_req", 32'(imem_req), 32'h0);

      do_reset();
      gen_instr(32'h00500093, TMO, 0, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_tmo_state", 32'(state), 32'h6);
      chk("lit_tmo_flag", 32'(timeout), 32'h1);
      do_reset();
      gen_instr(32'h00500093, TMO - 1, 0, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_ack_last_pc", pc, 32'h4);
      chk("lit_ack_last_tmo", 32'(timeout), 32'h0);
      // JALR to 0x103 clears bit 0 but still lands misaligned
      gen_instr(32'h000080E7, 0, 0, 1'b0, 32'h103, 1'b1); play(-1);
      chk("lit_jalr_state", 32'(state), 32'h6);
      chk("lit_jalr_illegal", 32'(illegal), 32'h1);
      chk("lit_jalr_pc", pc, 32'h4);

      do_reset();
      gen_instr(32'h0000A123, 0, TMO - 1, 1'b0, 32'h0, 1'b1);
      gen_instr(32'h0000A123, 0, TMO, 1'b0, 32'h0, 1'b1); play(-1);
      chk("lit_mem_tmo", 32'(timeout), 32'h1);

      do_reset();
      gen_instr(32'h00500093, 0, 0, 1'b0, 32'h0, 1'b1);
      gen_instr(32'h0000A103, 0, 10, 1'b0, 32'h0, 1'b1);
      play(q.size() - 5);
      chk("lit_mid_mem_req", 32'(dmem_req), 32'h1);
      #2 reset = 1;
      #1;
      chk("lit_async_dmem_req", 32'(dmem_req), 32'h0);
      chk("lit_async_state", 32'(state), 32'h0);
      do_reset();

      for (int e = 0; e < 25; e++) begin
         for (int i = 0; i < 8 && !m_trap; i++) begin gen_random(); play(-1); end
         do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rv32i_seq_ctrl.md
Name: rv32i_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the RV32I datapath unit.
- Owns the PC and fetches instructions over a request/ack instruction port.
- Classifies each opcode and steps the datapath through EXEC, MEM and WB with one-cycle strobes (alu_en, dmem_req, rf_we).
- Resolves next-PC from the datapath's branch flags and jump targets, and traps on illegal opcodes, misaligned targets or memory timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 16, max wait cycles for imem_ack/dmem_ack before trap (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; high permits starting new instructions
imem_req  out  1  instruction fetch request, held until ack
imem_addr  out  32  fetch address, equals pc while imem_req=1
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  1=store, 0=load; valid with dmem_req
dmem_ack  in  1  data access complete
branch_taken  in  1  OR of datapath beq/bneq/bgeq/blt outputs
branch_target  in  32  PC-relative branch target from datapath
jump_target  in  32  JAL/JALR target from datapath
instr_q  out  32  latched current instruction
alu_en  out  1  one-cycle ALU strobe
rf_we  out  1  one-cycle register write strobe
pc  out  32  current PC
state  out  3  FSM state encoding
retired  out  1  one-cycle pulse per completed instruction
illegal  out  1  sticky: bad opcode or misaligned target
timeout  out  1  sticky: memory ack timeout

Behaviour:
- Reset, asynchronous and immediate:
  - pc=RESET_PC, state=IDLE, instr_q=0.
  - All strobes and requests 0; illegal=0, timeout=0; wait counter 0.
  - Outstanding requests are dropped; a late ack after reset is ignored.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Encoding 7 is unreachable and recovers to IDLE.
- IDLE: run=1 -> FETCH on next edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr_q<=imem_rdata, -> DECODE.
  - Fetch latency is therefore 1 cycle minimum after the request (ack in the first FETCH cycle is legal).
- DECODE, opcode instr_q[6:0]:
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0010011 OP-IMM, 0110011 OP, 0110111 LUI, 0010111 AUIPC.
  - Any other opcode -> TRAP with illegal=1; otherwise -> EXEC.
- EXEC: alu_en=1 for exactly this cycle. Next state:
  - LOAD/STORE -> MEM.
  - BRANCH -> retire: pc<=branch_taken ? branch_target : pc+4.
  - All others -> WB.
- MEM: dmem_req=1, dmem_we=(STORE). On dmem_ack:
  - STORE -> retire with pc+4.
  - LOAD -> WB.
- WB: rf_we=1 for one cycle, then retire. Next PC:
  - JAL: jump_target.
  - JALR: {jump_target[31:1],1'b0}.
  - Otherwise: pc+4.
- Retire cycle:
  - retired=1 and pc updated on that edge.
  - Next state is FETCH if run=1, else IDLE.
  - PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC with +4 gives 0.
- Misaligned new PC (bits[1:0]!=0): pc is not updated, retired=0, -> TRAP with illegal=1.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and counts each cycle without ack.
  - If the count reaches TIMEOUT_CYCLES, the next state is TRAP with timeout=1 and the request is deasserted.
  - An ack arriving in the same cycle the count hits the limit wins: no trap.
- TRAP: absorbing until reset; all strobes and requests 0; pc frozen.
- run=0 mid-instruction: the current instruction completes; the block stops in IDLE after retire.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Outputs are registered except imem_addr (=pc).

Optional Feature:
- PERF_CNT_EN defined: adds outputs cycle_count[31:0] and instret_count[31:0].
  - cycle_count increments every cycle state!=IDLE and !=TRAP.
  - instret_count increments on each retired pulse.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports still exist but are tied to 0, with no counter logic.

Test Plan:
- Reset with run=1, ADDI 0x00500093 acked in 1 cycle -> states 1,2,3,5; rf_we pulse in WB; retired=1; pc 0->4; alu_en pulses once.
- LW 0x0000A103 with dmem_ack after 3 cycles -> dmem_req=1, dmem_we=0 for 3 cycles, then WB; rf_we=1; pc=8 when fetched at 4.
- BEQ at pc=0x10, branch_target=0x40: branch_taken=1 -> pc=0x40, no rf_we. Branch_taken=0 -> pc=0x14.
- Opcode 0x0000007F -> TRAP, illegal=1, imem_req stays 0; afterwards reset -> pc=RESET_PC, illegal=0.
- imem_ack withheld with TIMEOUT_CYCLES=16 -> TRAP entered after 16 wait cycles, timeout=1. Repeat with ack on the 16th cycle -> no trap.
- JALR with jump_target=0x103 -> pc=0x102 misaligned -> TRAP, illegal=1. Reset asserted mid-MEM -> dmem_req drops immediately.
